ser8_tx: RTL and testbench

Byte-serial transmitter: the send-side counterpart of the 8-bit capture register. It accepts one parallel byte on a load strobe and shifts it out on a single wire as a framed character: start bit, 8 data bits LSB first, stop bit. Each bit is held for a parameterised number of clocks. It sits between byte-producing logic and an off-block serial line whose far end deserialises the character and latches it into an 8-bit register.

---
 rtl/ser8_tx.sv | 90 +++++++++
 tb/tb_ser8_tx.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ser8_tx.sv
// Byte-serial transmitter: start bit, 8 data bits LSB first, stop bit,
// with each bit held for DIV clocks. All outputs are registered.
module ser8_tx #(
  parameter int unsigned DIV = 4
) (
  input  logic       CK,
  input  logic       RSTN,
  input  logic [7:0] I,
  input  logic       LD,
  output logic       RDY,
  output logic       SO,
  output logic       DONE
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        st;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;
  logic          last;

  assign last = (cnt == CMAX);

  always_ff @(posedge CK) begin
    if (!RSTN) begin
      st   <= IDLE;
      SO   <= 1'b1;
      RDY  <= 1'b1;
      DONE <= 1'b0;
      cnt  <= '0;
      idx  <= '0;
      sh   <= '0;
    end else begin
      DONE <= 1'b0;
      case (st)
        IDLE: begin
          if (LD) begin
            sh  <= I;
            st  <= START;
            SO  <= 1'b0;
            RDY <= 1'b0;
            cnt <= '0;
          end
        end
        START: begin
          if (last) begin
            cnt <= '0;
            idx <= '0;
            st  <= DATA;
            SO  <= sh[0];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (last) begin
            cnt <= '0;
            idx <= idx + 3'd1;
            sh  <= {1'b0, sh[7:1]};
            // sh[1] is the bit that becomes sh[0] after this shift
            if (idx == 3'd7) begin
              st <= STOP;
              SO <= 1'b1;
            end else begin
              SO <= sh[1];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (last) begin
            cnt  <= '0;
            st   <= IDLE;
            RDY  <= 1'b1;
            DONE <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ser8_tx.sv
// Scoreboard bench for ser8_tx: a DIV=4 and a DIV=1 instance, expected
// per-cycle {SO,RDY,DONE} queued at stimulus time and popped every cycle.
module tb_ser8_tx;

  typedef struct packed {
    logic so;
    logic rdy;
    logic done;
  } exp_t;

  logic       CK;
  logic       rstn;
  logic [7:0] i4, i1;
  logic       ld4, ld1;
  logic       rdy4, so4, done4;
  logic       rdy1, so1, done1;

  exp_t q4[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;

  ser8_tx #(.DIV(4)) dut4 (
    .CK(CK), .RSTN(rstn), .I(i4), .LD(ld4), .RDY(rdy4), .SO(so4), .DONE(done4)
  );

  ser8_tx #(.DIV(1)) dut1 (
    .CK(CK), .RSTN(rstn), .I(i1), .LD(ld1), .RDY(rdy1), .SO(so1), .DONE(done1)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Expected cycles T0+1 .. T0+10*d+1 for a frame accepted at edge T0.
  task automatic push_frame(input bit which, input logic [7:0] b);
    int   d;
    logic bv;
    exp_t e;
    d = which ? 1 : 4;
    for (int k = 0; k < 10; k++) begin
      bv = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      e  = {bv, 1'b0, 1'b0};
      for (int c = 0; c < d; c++) begin
        if (which) q1.push_back(e);
        else       q4.push_back(e);
      end
    end
    e = {1'b1, 1'b1, 1'b1};
    if (which) q1.push_back(e);
    else       q4.push_back(e);
  endtask

  // One clock edge, then compare both instances against their scoreboards;
  // an empty queue means the instance must be idle.
  task automatic cyc();
    exp_t e4, e1;
    @(posedge CK);
    #1;
    e4 = (q4.size() > 0) ? q4.pop_front() : exp_t'({1'b1, 1'b1, 1'b0});
    e1 = (q1.size() > 0) ? q1.pop_front() : exp_t'({1'b1, 1'b1, 1'b0});
    checks++;
    assert ({so4, rdy4, done4} === e4) else begin
      errors++;
      $error("FAIL div4 so/rdy/done at %0t: got %b expected %b", $time, {so4, rdy4, done4}, e4);
    end
    checks++;
    assert ({so1, rdy1, done1} === e1) else begin
      errors++;
      $error("FAIL div1 so/rdy/done at %0t: got %b expected %b", $time, {so1, rdy1, done1}, e1);
    end
  endtask

  initial begin
    // Reset held with LD high and I=0xFF: must stay idle
    rstn = 1'b0; ld4 = 1'b1; i4 = 8'hFF; ld1 = 1'b1; i1 = 8'hFF;
    repeat (3) cyc();
    ld4 = 1'b0; ld1 = 1'b0; rstn = 1'b1;
    repeat (3) cyc();

    // Single frame 0xA5; I changes after acceptance
    i4 = 8'hA5; ld4 = 1'b1; push_frame(1'b0, 8'hA5);
    cyc();
    ld4 = 1'b0; i4 = 8'h5A;
    repeat (40) cyc();
    repeat (3) cyc();

    // Busy ignore: LD pulses with 0x3C at edges T0+10 and T0+20
    i4 = 8'hA5; ld4 = 1'b1; push_frame(1'b0, 8'hA5);
    cyc();
    ld4 = 1'b0;
    repeat (9) cyc();
    ld4 = 1'b1; i4 = 8'h3C;
    cyc();
    ld4 = 1'b0;
    repeat (9) cyc();
    ld4 = 1'b1;
    cyc();
    ld4 = 1'b0;
    repeat (20) cyc();
    repeat (3) cyc();

    // Reset mid-frame at edge T0+15, then a clean 0x81 frame
    i4 = 8'h5A; ld4 = 1'b1; push_frame(1'b0, 8'h5A);
    cyc();
    ld4 = 1'b0;
    repeat (14) cyc();
    rstn = 1'b0;
    q4.delete();
    cyc();
    rstn = 1'b1;
    repeat (3) cyc();
    i4 = 8'h81; ld4 = 1'b1; push_frame(1'b0, 8'h81);
    cyc();
    ld4 = 1'b0;
    repeat (40) cyc();
    repeat (2) cyc();

    // Back-to-back: LD held, 0x00 then 0xFF accepted in the DONE cycle
    i4 = 8'h00; ld4 = 1'b1;
    push_frame(1'b0, 8'h00);
    push_frame(1'b0, 8'hFF);
    cyc();
    i4 = 8'hFF;
    repeat (40) cyc();
    cyc();
    ld4 = 1'b0;
    repeat (40) cyc();
    repeat (3) cyc();

    // DIV=1 instance, 0x01
    i1 = 8'h01; ld1 = 1'b1; push_frame(1'b1, 8'h01);
    cyc();
    ld1 = 1'b0; i1 = 8'hFE;
    repeat (10) cyc();
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
